multi_nch_disp: RTL and testbench
=================================

MULTI_NCH_DISP -- requirements
Module: multi_nch_disp

Interface
REQ-001 Parameter NUM_CH, default 8, number of display channels (2..16).
REQ-002 Parameter DATA_W, default 32, width of each channel's data word.
REQ-003 Parameter DWELL_CYC, default 100000000, clock cycles per channel in auto-scan mode (>=2).
REQ-004 Localparam SEL_W = clog2(NUM_CH), channel index width.
REQ-005 clk  input  1  system clock; the single clock for the block.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 en  input  1  update enable; 0 freezes all state and outputs.
REQ-008 sel  input  SEL_W  manual channel select.
REQ-009 auto  input  1  level request for auto-scan mode.
REQ-010 data_in  input  NUM_CH*DATA_W  packed channel data, channel k at bits [k*DATA_W +: DATA_W].
REQ-011 point_in  input  NUM_CH*8  packed per-channel decimal-point bytes.
REQ-012 le_in  input  NUM_CH*8  packed per-channel digit-enable bytes.
REQ-013 disp_num  output  DATA_W  registered data of the current channel.
REQ-014 point_out  output  8  registered point byte of the current channel.
REQ-015 le_out  output  8  registered digit-enable byte of the current channel.
REQ-016 cur_ch  output  SEL_W  registered current channel index.
REQ-017 ch_tick  output  1  one-cycle pulse on each auto-scan channel advance.

Function
REQ-018 States MANUAL and AUTO; the state register samples auto on every clk edge with en=1.
REQ-019 MANUAL: cur_ch loads sel each enabled cycle; sel >= NUM_CH clamps to NUM_CH-1.
REQ-020 MANUAL->AUTO (auto=1): cur_ch keeps its value; the dwell counter clears to 0.
REQ-021 AUTO: the dwell counter counts 0..DWELL_CYC-1; at DWELL_CYC-1 it wraps to 0, cur_ch increments (NUM_CH-1 wraps to 0), and ch_tick = 1 for that cycle only.
REQ-022 AUTO->MANUAL (auto=0): cur_ch loads the clamped sel on the same edge; the counter clears; ch_tick = 0.
REQ-023 disp_num, point_out and le_out equal the slices of the channel indexed by cur_ch's next value, registered on the same edge; latency from sel or data change is 1 cycle.
REQ-024 en=0: counter, state, cur_ch and all outputs hold; ch_tick = 0; the cycle does not count toward the dwell.
REQ-025 Channel data changes while cur_ch is stable appear on the outputs 1 cycle later.
REQ-026 ch_tick is never asserted in MANUAL.

Reset
REQ-027 rst=1 asynchronously forces state MANUAL, counter 0, cur_ch 0, disp_num 0, point_out 8'h00, le_out 8'h00, ch_tick 0.
REQ-028 Reset mid-dwell discards the partial count; after release the block is in MANUAL and follows sel on the first enabled edge.

Configuration
REQ-029 Macro MULTI_NCH_DISP_AUTOSCAN_EN defined: AUTO state, dwell counter and ch_tick are present as specified.
REQ-030 Macro undefined: auto is ignored, the state is permanently MANUAL, no dwell counter is synthesised, and ch_tick is tied 0.

Structure
REQ-031 Shared package multi_disp_pkg holds the MANUAL/AUTO state enum, the default NUM_CH/DATA_W/DWELL_CYC constants and the 8-bit byte width constant.
REQ-032 Sub-module dwell_timer (parameter DWELL_CYC; ports clk, rst, en, clr; terminal-pulse output) implements the dwell counter and is instantiated only under MULTI_NCH_DISP_AUTOSCAN_EN.

Verification (NUM_CH=8, DATA_W=32, DWELL_CYC=4, channel k data = 32'h1111_1111*k)
REQ-033 Manual: sel=3, en=1 -> after 1 edge disp_num=32'h3333_3333, cur_ch=3, ch_tick=0.
REQ-034 Auto: set auto=1 at cur_ch=6 -> ch_tick pulses every 4 cycles; cur_ch steps 7, 0, 1; disp_num tracks 1 cycle after each cur_ch change.
REQ-035 Freeze: in AUTO, drop en for 10 cycles mid-dwell -> outputs and cur_ch unchanged; the next tick occurs after the remaining dwell cycles once en=1.
REQ-036 Exit auto: auto 1->0 with sel=2 -> next edge cur_ch=2, disp_num=32'h2222_2222, and no further ticks.
REQ-037 Reset: assert rst asynchronously mid-dwell at cur_ch=5 -> all outputs 0 immediately without a clock edge; after release the block is in MANUAL with cur_ch=0.
REQ-038 Without MULTI_NCH_DISP_AUTOSCAN_EN: auto=1 for 20 cycles -> ch_tick stays 0 and cur_ch follows sel.

Source files
------------

// File: rtl/multi_disp_pkg.sv
// Shared types and defaults for the multi-channel display selector.
// Holds the MANUAL/AUTO mode enum, default sizes and the byte width.
package multi_disp_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } disp_mode_t;

  localparam int DEF_NUM_CH    = 8;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DWELL_CYC = 100000000;
  localparam int BYTE_W        = 8;

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for auto-scan: counts 0..DWELL_CYC-1 on enabled cycles.
// Ports: clk, rst (async high), en (count enable), clr (hold at 0),
//        tick (high while at the last count and not cleared).
module dwell_timer
  import multi_disp_pkg::*;
#(
  parameter int DWELL_CYC = DEF_DWELL_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(DWELL_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYC - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = !clr && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (clr || tick) cnt <= '0;
      else             cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multi_nch_disp.sv
// Selects one of NUM_CH display channels, manually via sel or by auto-scan.
// Ports: clk, rst (async high), en (update enable), sel, auto,
//        data_in/point_in/le_in (packed per channel) ->
//        disp_num, point_out, le_out, cur_ch (registered), ch_tick.
// Auto-scan is built only when MULTI_NCH_DISP_AUTOSCAN_EN is defined.
module multi_nch_disp
  import multi_disp_pkg::*;
#(
  parameter  int NUM_CH    = DEF_NUM_CH,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int DWELL_CYC = DEF_DWELL_CYC,
  localparam int SEL_W     = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     auto,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [NUM_CH*BYTE_W-1:0] point_in,
  input  logic [NUM_CH*BYTE_W-1:0] le_in,
  output logic [DATA_W-1:0]        disp_num,
  output logic [BYTE_W-1:0]        point_out,
  output logic [BYTE_W-1:0]        le_out,
  output logic [SEL_W-1:0]         cur_ch,
  output logic                     ch_tick
);

  logic [SEL_W-1:0]  sel_clamp;
  logic [SEL_W-1:0]  nxt_ch;
  logic [DATA_W-1:0] nxt_data;
  logic [BYTE_W-1:0] nxt_pt;
  logic [BYTE_W-1:0] nxt_le;

  always_comb begin
    sel_clamp = sel;
    if (int'(sel) >= NUM_CH) sel_clamp = SEL_W'(NUM_CH - 1);
  end

`ifdef MULTI_NCH_DISP_AUTOSCAN_EN
  disp_mode_t       state;
  logic             scan;
  logic             tick;
  logic             adv;
  logic [SEL_W-1:0] inc_ch;

  // Counter runs only while already in AUTO and still requested,
  // so the entry cycle starts the dwell from 0.
  assign scan = auto && (state == AUTO);
  assign adv  = scan && tick;

  dwell_timer #(
    .DWELL_CYC(DWELL_CYC)
  ) u_dwell (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (!scan),
    .tick(tick)
  );

  assign inc_ch = (cur_ch == SEL_W'(NUM_CH - 1)) ? '0
                                                 : cur_ch + SEL_W'(1);

  always_comb begin
    nxt_ch = cur_ch;
    if (!auto)    nxt_ch = sel_clamp;
    else if (adv) nxt_ch = inc_ch;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MANUAL;
      ch_tick <= 1'b0;
    end else if (en) begin
      state   <= auto ? AUTO : MANUAL;
      ch_tick <= adv;
    end else begin
      ch_tick <= 1'b0;
    end
  end
`else
  logic        unused_auto;
  logic [31:0] unused_dwell;

  assign unused_auto  = auto;
  assign unused_dwell = 32'(DWELL_CYC);
  assign nxt_ch       = sel_clamp;
  assign ch_tick      = 1'b0;
`endif

  // Outputs follow the channel being loaded on this edge.
  always_comb begin
    nxt_data = '0;
    nxt_pt   = '0;
    nxt_le   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (nxt_ch == SEL_W'(k)) begin
        nxt_data = data_in[k*DATA_W +: DATA_W];
        nxt_pt   = point_in[k*BYTE_W +: BYTE_W];
        nxt_le   = le_in[k*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_ch    <= '0;
      disp_num  <= '0;
      point_out <= '0;
      le_out    <= '0;
    end else if (en) begin
      cur_ch    <= nxt_ch;
      disp_num  <= nxt_data;
      point_out <= nxt_pt;
      le_out    <= nxt_le;
    end
  end

endmodule

// File: tb/tb_multi_nch_disp.sv
// Self-checking bench for multi_nch_disp: vector table, corner
// sequences and a randomized run against a behavioural model.
module tb_multi_nch_disp;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [2:0]    sel;
  logic          auto;
  logic [N*DW-1:0] data_in;
  logic [N*8-1:0]  point_in;
  logic [N*8-1:0]  le_in;
  logic [DW-1:0] disp_num;
  logic [7:0]    point_out;
  logic [7:0]    le_out;
  logic [2:0]    cur_ch;
  logic          ch_tick;

  logic [2:0]  sel5;
  logic        auto5 = 1'b0;
  logic [39:0] data5 = {8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
  logic [39:0] pt5 = '0;
  logic [39:0] le5 = '0;
  logic [7:0]  d5;
  logic [7:0]  p5;
  logic [7:0]  l5;
  logic [2:0]  c5;
  logic        t5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multi_nch_disp #(
    .NUM_CH(N), .DATA_W(DW), .DWELL_CYC(DC)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .auto(auto),
    .data_in(data_in), .point_in(point_in), .le_in(le_in),
    .disp_num(disp_num), .point_out(point_out), .le_out(le_out),
    .cur_ch(cur_ch), .ch_tick(ch_tick)
  );

  multi_nch_disp #(
    .NUM_CH(5), .DATA_W(8), .DWELL_CYC(3)
  ) u5 (
    .clk(clk), .rst(rst), .en(en), .sel(sel5), .auto(auto5),
    .data_in(data5), .point_in(pt5), .le_in(le5),
    .disp_num(d5), .point_out(p5), .le_out(l5),
    .cur_ch(c5), .ch_tick(t5)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: mode flag, cycles spent in the current dwell,
  // current channel; outputs are the slices of that channel.
  bit        m_auto;
  int        m_dwell;
  int        m_cur;
  logic [31:0] m_data;
  logic [7:0]  m_pt;
  logic [7:0]  m_le;
  bit        m_tick;

  task automatic model_reset();
    m_auto = 0; m_dwell = 0; m_cur = 0;
    m_data = '0; m_pt = '0; m_le = '0; m_tick = 0;
  endtask

  task automatic model_edge();
    if (!en) begin
      m_tick = 0;
      return;
    end
    m_tick = 0;
`ifdef MULTI_NCH_DISP_AUTOSCAN_EN
    if (auto) begin
      if (!m_auto) begin
        m_auto  = 1;
        m_dwell = 0;
      end else begin
        m_dwell++;
        if (m_dwell == DC) begin
          m_dwell = 0;
          m_cur   = (m_cur + 1) % N;
          m_tick  = 1;
        end
      end
    end else begin
      m_auto  = 0;
      m_dwell = 0;
      m_cur   = (int'(sel) >= N) ? N - 1 : int'(sel);
    end
`else
    m_cur = (int'(sel) >= N) ? N - 1 : int'(sel);
`endif
    m_data = data_in[m_cur*DW +: DW];
    m_pt   = point_in[m_cur*8 +: 8];
    m_le   = le_in[m_cur*8 +: 8];
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic        en;
    logic [2:0]  sel5;
    logic [2:0]  ch;
    logic [31:0] dat;
    logic [2:0]  ch5;
    logic [7:0]  d5;
  } vec_t;

  vec_t tbl[6];
  int   ecur;
  bit   eadv;

  initial begin
    tbl[0] = '{3'd3, 1'b1, 3'd6, 3'd3, 32'h3333_3333, 3'd4, 8'h44};
    tbl[1] = '{3'd7, 1'b1, 3'd2, 3'd7, 32'h7777_7777, 3'd2, 8'h22};
    tbl[2] = '{3'd0, 1'b1, 3'd7, 3'd0, 32'h0000_0000, 3'd4, 8'h44};
    tbl[3] = '{3'd5, 1'b0, 3'd1, 3'd0, 32'h0000_0000, 3'd4, 8'h44};
    tbl[4] = '{3'd5, 1'b1, 3'd1, 3'd5, 32'h5555_5555, 3'd1, 8'h11};
    tbl[5] = '{3'd4, 1'b1, 3'd5, 3'd4, 32'h4444_4444, 3'd4, 8'h44};

    for (int k = 0; k < N; k++) begin
      data_in[k*DW +: DW] = 32'h1111_1111 * k;
      point_in[k*8 +: 8]  = 8'h10 + 8'(k);
      le_in[k*8 +: 8]     = 8'hA0 + 8'(k);
    end
    rst = 1'b1; en = 1'b0; sel = '0; auto = 1'b0; sel5 = '0;
    #1;
    chk("reset_disp", disp_num, 0);
    chk("reset_cur", cur_ch, 0);
    chk("reset_bytes", {point_out, le_out, 7'd0, ch_tick}, 0);
    #10 rst = 1'b0;
    cyc();

    foreach (tbl[i]) begin
      sel = tbl[i].sel; en = tbl[i].en; sel5 = tbl[i].sel5;
      cyc();
      chk($sformatf("tbl%0d_cur", i), cur_ch, tbl[i].ch);
      chk($sformatf("tbl%0d_disp", i), disp_num, tbl[i].dat);
      chk($sformatf("tbl%0d_pt", i), point_out, 8'h10 + 8'(tbl[i].ch));
      chk($sformatf("tbl%0d_le", i), le_out, 8'hA0 + 8'(tbl[i].ch));
      chk($sformatf("tbl%0d_tick", i), ch_tick, 0);
      chk($sformatf("tbl%0d_clamp", i), {c5, d5}, {tbl[i].ch5, tbl[i].d5});
    end
    en = 1'b1;

`ifdef MULTI_NCH_DISP_AUTOSCAN_EN
    sel = 3'd6;
    cyc();
    chk("pre_auto_cur", cur_ch, 6);
    auto = 1'b1;
    sel  = 3'd0;
    ecur = 6;
    for (int i = 1; i <= 13; i++) begin
      cyc();
      eadv = (i >= 5) && ((i - 1) % 4 == 0);
      if (eadv) ecur = (ecur + 1) % N;
      chk($sformatf("auto%0d_tick", i), ch_tick, eadv);
      chk($sformatf("auto%0d_cur", i), cur_ch, ecur);
      chk($sformatf("auto%0d_disp", i), disp_num, 32'h1111_1111 * ecur);
    end
    cyc();
    cyc();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("freeze_cur", cur_ch, 1);
      chk("freeze_tick", ch_tick, 0);
      chk("freeze_disp", disp_num, 32'h1111_1111);
    end
    en = 1'b1;
    cyc();
    chk("resume1_tick", ch_tick, 0);
    chk("resume1_cur", cur_ch, 1);
    cyc();
    chk("resume2_tick", ch_tick, 1);
    chk("resume2_cur", cur_ch, 2);
    for (int i = 0; i < 4; i++) cyc();
    chk("pre_exit_cur", {cur_ch, 7'd0, ch_tick}, {3'd3, 8'd1});
    auto = 1'b0;
    sel  = 3'd2;
    cyc();
    chk("exit_cur", cur_ch, 2);
    chk("exit_disp", disp_num, 32'h2222_2222);
    chk("exit_tick", ch_tick, 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("manual_no_tick", {cur_ch, 7'd0, ch_tick}, {3'd2, 8'd0});
    end
    sel = 3'd5;
    cyc();
    auto = 1'b1;
    cyc();
    cyc();
    chk("pre_rst_cur", cur_ch, 5);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_disp", disp_num, 0);
    chk("async_rst_cur", cur_ch, 0);
    chk("async_rst_bytes", {point_out, le_out, 7'd0, ch_tick}, 0);
    #1 rst = 1'b0;
    auto = 1'b0;
    sel  = 3'd4;
    cyc();
    chk("post_rst_cur", cur_ch, 4);
    chk("post_rst_disp", disp_num, 32'h4444_4444);
`else
    auto = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sel = 3'($urandom);
      cyc();
      chk("noauto_cur", cur_ch, sel);
      chk("noauto_tick", ch_tick, 0);
    end
    auto = 1'b0;
    sel  = 3'd5;
    cyc();
    #3 rst = 1'b1;
    #1;
    chk("async_rst_disp", disp_num, 0);
    chk("async_rst_cur", cur_ch, 0);
    #1 rst = 1'b0;
    sel = 3'd4;
    cyc();
    chk("post_rst_cur", cur_ch, 4);
`endif

    rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    auto = 1'b0;
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) auto = ~auto;
      if ($urandom_range(0, 3) == 0) sel = 3'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        for (int k = 0; k < N; k++) begin
          data_in[k*DW +: DW] = $urandom;
          point_in[k*8 +: 8]  = 8'($urandom);
          le_in[k*8 +: 8]     = 8'($urandom);
        end
      end
      model_edge();
      cyc();
      chk($sformatf("rnd%0d_cur", c), cur_ch, m_cur);
      chk($sformatf("rnd%0d_out", c), {disp_num, point_out, le_out},
          {m_data, m_pt, m_le});
      chk($sformatf("rnd%0d_tick", c), ch_tick, m_tick);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
